// File: rtl/score_pkg.sv
// Shared types and constants for the score binary-to-BCD converter.
// LEADING_ZERO_BLANK_EN selects leading-zero blanking in the top module.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PEND  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Largest value representable in nd decimal digits (10^nd - 1).
    function automatic int unsigned max_dec(input int nd);
        int unsigned r;
        r = 1;
        for (int i = 0; i < nd; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

    // Width of a down-counter that must hold the value w.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/score_bcd_converter_bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter whose digit bus only changes
// on a frame_end strobe. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BIN_W-1:0]       bin_in,
    input  logic                   frame_end,
    output logic                   busy,
    output logic                   done,
    output logic                   updated,
    output logic                   overflow,
    output logic [4*NDIGITS-1:0]   digits
);

    localparam int          BCD_W   = 4 * NDIGITS;
    localparam int          CNT_W   = cnt_w(BIN_W);
    localparam int unsigned MAX_VAL = max_dec(NDIGITS);
    localparam logic [BCD_W-1:0] NINES = {NDIGITS{4'h9}};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [BCD_W-1:0] RESET_DIGITS = {{(NDIGITS-1){BCD_BLANK}}, 4'h0};
`else
    localparam logic [BCD_W-1:0] RESET_DIGITS = '0;
`endif

    state_t                 state_q, state_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [BCD_W-1:0]       shadow_q, shadow_d;
    logic                   shadow_ovf_q, shadow_ovf_d;
    logic [BCD_W-1:0]       digits_q, digits_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [BCD_W-1:0]       commit_val;

    genvar gi;
    generate
        for (gi = 0; gi < NDIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .nib_i (bcd_q[gi*4 +: 4]),
                .nib_o (bcd_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Bits leaving the BCD MSB are dropped; saturated inputs bypass this result.
    assign shifted = {bcd_adj, bin_q} << 1;

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic seen;
        seen       = 1'b0;
        commit_val = shadow_q;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            if (shadow_q[i*4 +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            if (!seen) begin
                commit_val[i*4 +: 4] = BCD_BLANK;
            end
        end
    end
`else
    assign commit_val = shadow_q;
`endif

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        shadow_d     = shadow_q;
        shadow_ovf_d = shadow_ovf_q;
        digits_d     = digits_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    sat_d   = (32'(bin_in) > MAX_VAL);
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = shifted[BCD_W+BIN_W-1:BIN_W];
                bin_d = shifted[BIN_W-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = PEND;
                    done_d       = 1'b1;
                    shadow_d     = sat_q ? NINES : shifted[BCD_W+BIN_W-1:BIN_W];
                    shadow_ovf_d = sat_q;
                end
            end
            PEND: begin
                if (frame_end) begin
                    digits_d = commit_val;
                    ovf_d    = shadow_ovf_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            shadow_q     <= '0;
            shadow_ovf_q <= 1'b0;
            digits_q     <= RESET_DIGITS;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            shadow_q     <= shadow_d;
            shadow_ovf_q <= shadow_ovf_d;
            digits_q     <= digits_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign updated  = (state_q == PEND) && frame_end && !rst;
    assign overflow = ovf_q;
    assign digits   = digits_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// Randomized and directed bench for score_bcd_converter against a decimal
// arithmetic model of conversion latency, frame-gated commit and saturation.
module tb_score_bcd_converter;

    localparam int BIN_W = 14;
    localparam int ND    = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [15:0] RST_DIGITS = 16'hFFF0;
    localparam logic [15:0] ZERO_DIG   = 16'hFFF0;
    localparam logic [15:0] D42        = 16'hFF42;
`else
    localparam logic [15:0] RST_DIGITS = 16'h0000;
    localparam logic [15:0] ZERO_DIG   = 16'h0000;
    localparam logic [15:0] D42        = 16'h0042;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             frame_end = 1'b0;
    logic             busy, done, updated, overflow;
    logic [4*ND-1:0]  digits;

    score_bcd_converter #(.BIN_W(BIN_W), .NDIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin_in    (bin_in),
        .frame_end (frame_end),
        .busy      (busy),
        .done      (done),
        .updated   (updated),
        .overflow  (overflow),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal rendering of a value as the display should show it.
    function automatic logic [15:0] exp_digits(input int v);
        logic [15:0] r;
        int x;
        if (v > 9999) return 16'h9999;
        x = v;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = ND - 1; i >= 1; i--) begin
            if (r[i*4 +: 4] != 4'h0) break;
            r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // Model: phase 0 idle, 1 converting (m_left edges to go), 2 waiting for frame.
    int          m_phase = 0;
    int          m_left  = 0;
    bit          m_done  = 1'b0;
    bit          m_nd    = 1'b0;
    logic [15:0] m_digits = '0;
    logic [15:0] m_pend   = '0;
    bit          m_ovf = 1'b0;
    bit          m_pend_ovf = 1'b0;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_done   = 1'b0;
            m_digits = RST_DIGITS;
            m_ovf    = 1'b0;
            armed    = 1'b1;
        end else begin
            m_nd = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_pend     = exp_digits(int'(bin_in));
                    m_pend_ovf = (int'(bin_in) > 9999);
                    m_left     = BIN_W;
                    m_phase    = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_nd    = 1'b1;
                    end
                end
                default: if (frame_end) begin
                    m_digits = m_pend;
                    m_ovf    = m_pend_ovf;
                    m_phase  = 0;
                end
            endcase
            m_done = m_nd;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("done", 32'(done), 32'(m_done));
            check("updated", 32'(updated), 32'(m_phase == 2 && frame_end && !rst));
            check("digits", 32'(digits), 32'(m_digits));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (done === 1'b1) done_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic run_one(input int v, input logic [15:0] ed, input logic eo);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        wait_done();
        tick();
        tick();
        frame_end = 1'b1;
        #1;
        check("commit_updated", 32'(updated), 32'd1);
        tick();
        frame_end = 1'b0;
        check("commit_digits", 32'(digits), 32'(ed));
        check("commit_ovf", 32'(overflow), 32'(eo));
        check("commit_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int dc;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_digits", 32'(digits), 32'(RST_DIGITS));
        check("reset_busy", 32'(busy), 32'd0);

        // 1234: done exactly 15 cycles after the start cycle, digits held until frame.
        bin_in = 14'd1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        check("done_early", 32'(done), 32'd0);
        tick();
        check("done_on_time", 32'(done), 32'd1);
        tick();
        check("done_single", 32'(done), 32'd0);
        check("digits_held", 32'(digits), 32'(RST_DIGITS));
        for (int k = 0; k < 12; k++) tick();
        frame_end = 1'b1;
        #1;
        check("upd_1234", 32'(updated), 32'd1);
        tick();
        frame_end = 1'b0;
        check("digits_1234", 32'(digits), 32'h1234);
        check("ovf_1234", 32'(overflow), 32'd0);

        run_one(0, ZERO_DIG, 1'b0);
        run_one(9999, 16'h9999, 1'b0);
        run_one(12000, 16'h9999, 1'b1);
        run_one(42, D42, 1'b0);

        // Start while busy is ignored; frame_end during SHIFT does nothing.
        dc = done_count;
        bin_in = 14'd1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        bin_in = 14'd77;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("no_early_commit", 32'(digits), 32'(D42));
        wait_done();
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        check("ignored_start_digits", 32'(digits), 32'h1234);
        check("single_done", 32'(done_count - dc), 32'd1);

        // Reset mid-conversion aborts without a commit.
        dc = done_count;
        bin_in = 14'd1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 20; k++) begin
            frame_end = (k % 5 == 0);
            tick();
        end
        frame_end = 1'b0;
        check("abort_digits", 32'(digits), 32'(RST_DIGITS));
        check("abort_no_done", 32'(done_count - dc), 32'd0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: bin_in = BIN_W'($urandom_range(0, 16383));
                1: bin_in = BIN_W'($urandom_range(0, 9999));
                2: bin_in = BIN_W'($urandom_range(9995, 10005));
                default: bin_in = BIN_W'($urandom_range(0, 120));
            endcase
            frame_end = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        start = 1'b0;
        frame_end = 1'b0;
        rst = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that produces the per-digit 4-bit values consumed by the displaydigit instances. It accepts a binary score or count from game logic and converts it over multiple cycles. The displayed digit bus updates only on a frame boundary strobe from the VGA timing logic, so a digit never changes mid-frame and never tears.

Parameters:
BIN_W, 14, width of binary input; 14 covers 0..16383.
NDIGITS, 4, number of BCD digits produced; max displayable value is 10^NDIGITS-1.

Ports:
clk  input  1  system clock (pixel clock domain).
rst  input  1  synchronous, active-high reset.
start  input  1  request conversion of bin_in; sampled only when busy=0.
bin_in  input  BIN_W  unsigned binary value, captured on the accepted start.
frame_end  input  1  single-cycle strobe at start of vertical blanking.
busy  output  1  high from the cycle after an accepted start until the commit cycle, inclusive.
done  output  1  one-cycle pulse when conversion finishes; result is pending commit.
updated  output  1  one-cycle pulse in the cycle the digits output changes.
overflow  output  1  registered with digits; high if the committed value was saturated.
digits  output  4*NDIGITS  committed BCD digits; [3:0] is least significant; each nibble feeds one displaydigit val.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE; busy=0, done=0, updated=0, overflow=0, digits all 4'h0. Shadow registers and iteration counter are cleared. Reset during SHIFT or PEND aborts the conversion with no commit.
- FSM states: IDLE, SHIFT, PEND.
- IDLE, start=1 at edge T:
  - capture bin_in into the shift register.
  - compute sat = (bin_in > 10^NDIGITS-1).
  - clear the BCD accumulator and set counter=BIN_W.
  - go to SHIFT. busy=1 from T+1.
- SHIFT, one iteration per cycle:
  - every BCD nibble >=5 gets +3 (combinational).
  - then {bcd, bin} shifts left by 1 and counter decrements.
  - after BIN_W iterations, go to PEND and pulse done=1 for exactly one cycle, at T+BIN_W+1.
  - shadow = sat ? all 4'h9 : bcd; shadow_ovf = sat.
- PEND: wait for frame_end.
  - on frame_end=1: digits<=shadow, overflow<=shadow_ovf, updated=1 for one cycle, go to IDLE. busy drops on the following cycle.
  - frame_end in IDLE or SHIFT has no effect.
- start while busy=1 (SHIFT or PEND) is ignored and not queued.
- digits and overflow hold their value between commits. They change only on the updated cycle.
- Nibble arithmetic: the 4-bit add-3 never exceeds 4'hC before the shift, and bcd width is 4*NDIGITS. Bits shifted out of the BCD MSB are discarded; correctness in that case relies on the sat path.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: at commit, every nibble above the most significant nonzero digit is replaced by BCD_BLANK (4'hF), so displaydigit shows background. Digit 0 is never blanked, so value 0 displays as a single "0". The reset value of digits is BCD_BLANK for nibbles [NDIGITS-1:1] and 4'h0 for nibble 0.
- Undefined: leading zeros are shown and the reset value is all zeros.

Decomposition:
- Package score_pkg holds:
  - the state enum (IDLE, SHIFT, PEND).
  - BCD_BLANK = 4'hF.
  - a constant function max_dec(NDIGITS) returning 10^NDIGITS-1.
  - a clog2-based counter width for BIN_W.
- Sub-module bcd_add3: combinational 4-bit nibble corrector (in >=5 ? in+3 : in), instantiated NDIGITS times via generate.

Test Plan:
- start with bin_in=1234 at T, frame_end at T+30 -> done pulse at T+15; digits=16'h1234, updated=1 and overflow=0 at T+30; digits unchanged at T+16..T+29.
- bin_in=0 -> digits=16'h0000, or 16'hFFF0 with LEADING_ZERO_BLANK_EN; bin_in=9999 -> 16'h9999, overflow=0.
- bin_in=12000 -> digits=16'h9999, overflow=1; then bin_in=42 -> 16'h0042 (16'hFF42 with macro), overflow=0.
- Pulse start=1 with bin_in=77 at T+5 during a 1234 conversion -> ignored; committed digits=16'h1234; only one done pulse.
- frame_end pulses during SHIFT (T+3, T+8) -> no update; first frame_end in PEND commits.
- rst=1 for one cycle at T+7 mid-conversion, then frame_end -> no done, no updated; digits equal the reset value; busy=0 after reset.
